// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary pointer helpers and read-mode names shared by the FIFO read/write controllers
package fifo_pkg;
  localparam string FT_TRUE  = "TRUE";
  localparam string FT_FALSE = "FALSE";
  // Both helpers work on any pointer width up to 32 bits: zero-extend in, truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side pointer/flag controller with valid/ready consumer port
// Optional rlevel output (unfetched word count) is enabled by defining FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int    ADDRSIZE      = 4,
  parameter string FALLTHROUGH   = "TRUE",
  parameter int    AREMPTY_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDRSIZE:0]   rlevel,
`endif
  output logic                arempty
);
  localparam int PW = ADDRSIZE + 1;
  localparam bit FT = (FALLTHROUGH == FT_TRUE);
  localparam logic [PW-1:0] AE_LVL = PW'(AREMPTY_LEVEL);
  logic [PW-1:0] rbin_q, rbin_d, rptr_q, rptr_d, wbin, count;
  logic          rempty_q, rempty_d, arempty_q, arempty_d, rvalid_q, rvalid_d, fetch;
  // Flags are computed against the post-fetch pointer so a same-edge fetch is reflected at once.
  always_comb begin
    rd_valid  = FT ? !rempty_q : rvalid_q;
    fetch     = rrst_n & !rempty_q & (FT ? rd_ready : (!rvalid_q | rd_ready));
    rbin_d    = rbin_q + PW'(fetch);
    rptr_d    = PW'(bin2gray(32'(rbin_d)));
    wbin      = PW'(gray2bin(32'(rq2_wptr)));
    count     = wbin - rbin_d;
    rempty_d  = rptr_d == rq2_wptr;
    arempty_d = count <= AE_LVL;
    rvalid_d  = !FT & (fetch | (rvalid_q & !rd_ready));
  end
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rempty_d;
      arempty_q <= arempty_d;
      rvalid_q  <= rvalid_d;
    end
  end
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rlevel_q;
  always_ff @(posedge rclk) rlevel_q <= rrst_n ? count : '0;
  assign rlevel = rlevel_q;
`endif
  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rclken  = fetch;
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign arempty = arempty_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: fall-through and registered read controllers checked against an occupancy-count model
module tb_fifo_rd_ctrl;
  logic       rclk = 1'b0, rrst_n, rdy_ft, rdy_rg;
  logic [4:0] rq2_wptr;
  logic       vld_ft, vld_rg, ce_ft, ce_rg, emp_ft, emp_rg, ae_ft, ae_rg;
  logic [3:0] ra_ft, ra_rg;
  logic [4:0] rp_ft, rp_rg, lvl_ft, lvl_rg;
  int total = 0, bad = 0, wr = 0;
  int m_rd[2], m_lvl[2];
  bit m_emp[2], m_ae[2], m_vld[2];
  always #5 rclk = ~rclk;
  fifo_rd_ctrl #(.ADDRSIZE(4), .FALLTHROUGH("TRUE"), .AREMPTY_LEVEL(2)) u_ft (
    .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rd_ready(rdy_ft), .rd_valid(vld_ft),
    .raddr(ra_ft), .rclken(ce_ft), .rptr(rp_ft), .rempty(emp_ft),
`ifdef FIFO_RD_LEVEL_EN
    .rlevel(lvl_ft),
`endif
    .arempty(ae_ft));
  fifo_rd_ctrl #(.ADDRSIZE(4), .FALLTHROUGH("FALSE"), .AREMPTY_LEVEL(2)) u_rg (
    .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rd_ready(rdy_rg), .rd_valid(vld_rg),
    .raddr(ra_rg), .rclken(ce_rg), .rptr(rp_rg), .rempty(emp_rg),
`ifdef FIFO_RD_LEVEL_EN
    .rlevel(lvl_rg),
`endif
    .arempty(ae_rg));
`ifndef FIFO_RD_LEVEL_EN
  assign lvl_ft = '0;
  assign lvl_rg = '0;
`endif
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction
  // Registered mode holds one word at the output; fall-through shows memory data directly.
  function automatic bit m_valid(input int i);
    return i == 0 ? !m_emp[0] : m_vld[1];
  endfunction
  function automatic bit m_fetch(input int i, input bit rst_n, input bit rdy);
    return rst_n && !m_emp[i] && (i == 0 ? rdy : (!m_vld[1] || rdy));
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = 0; m_lvl[i] = 0; m_emp[i] = 1; m_ae[i] = 1; m_vld[i] = 0;
    end
  endtask
  task automatic check_dut(input int i, input string nm, input bit rdy, input logic vld,
                           input logic [3:0] ra, input logic ce, input logic [4:0] rp,
                           input logic e, input logic a, input logic [4:0] lv);
    check({nm, "_valid"}, int'(vld), int'(m_valid(i)));
    check({nm, "_raddr"}, int'(ra), m_rd[i] % 16);
    check({nm, "_rclken"}, int'(ce), int'(m_fetch(i, rrst_n, rdy)));
    check({nm, "_rptr"}, int'(rp), gray(m_rd[i] % 32));
    check({nm, "_rempty"}, int'(e), int'(m_emp[i]));
    check({nm, "_arempty"}, int'(a), int'(m_ae[i]));
`ifdef FIFO_RD_LEVEL_EN
    check({nm, "_rlevel"}, int'(lv), m_lvl[i]);
`endif
  endtask
  task automatic cyc(input bit rst_n, input int w, input bit r0, input bit r1);
    bit f[2];
    bit r[2];
    rrst_n = rst_n; wr = w; rq2_wptr = 5'(gray(w % 32)); rdy_ft = r0; rdy_rg = r1;
    r[0] = r0; r[1] = r1;
    @(negedge rclk);
    check_dut(0, "ft", r0, vld_ft, ra_ft, ce_ft, rp_ft, emp_ft, ae_ft, lvl_ft);
    check_dut(1, "rg", r1, vld_rg, ra_rg, ce_rg, rp_rg, emp_rg, ae_rg, lvl_rg);
    @(posedge rclk);
    for (int i = 0; i < 2; i++) f[i] = m_fetch(i, rst_n, r[i]);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) begin
      m_rd[i] += int'(f[i]);
      m_lvl[i] = w - m_rd[i];
      m_emp[i] = m_lvl[i] == 0;
      m_ae[i]  = m_lvl[i] <= 2;
      if (i == 1) m_vld[1] = f[1] || (m_vld[1] && !r[1]);
    end
    #1;
  endtask
  initial begin
    int w, lo;
    bit rs;
    rrst_n = 0; rq2_wptr = '0; rdy_ft = 0; rdy_rg = 0;
    model_reset();
    @(posedge rclk);
    #1;
    repeat (3) cyc(0, 3, 1, 1);
    repeat (6) cyc(1, 3, 1, 1);
    check("drain_rptr", int'(rp_ft), 5'b00010);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 2, 1, 0);
    repeat (3) cyc(1, 2, 1, 1);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 2, 0, 0);
    cyc(0, 2, 0, 0);
    repeat (3) cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (18) cyc(1, 15, 1, 1);
    repeat (6) cyc(1, 18, 1, 1);
    check("wrap_rptr", int'(rp_ft), 5'b11011);
    check("wrap_rempty", int'(emp_ft), 1);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 4, 0, 0);
    repeat (5) cyc(1, 4, 1, 1);
    for (int n = 0; n < 800; n++) begin
      rs = $urandom_range(0, 99) != 0;
      lo = m_rd[0] < m_rd[1] ? m_rd[0] : m_rd[1];
      w = rs ? wr + int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      if (rs && w > lo + 16) w = lo + 16;
      cyc(rs, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
